// File: rtl/vram_seq_pkg.sv
// Shared types and address-split helpers for the bitmap VRAM sequencer.
package vram_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ROW      = 3'd1,
    S_COL      = 3'd2,
    S_DATA     = 3'd3,
    S_PRE      = 3'd4,
    S_REF_ROW  = 3'd5,
    S_REF_HOLD = 3'd6
  } state_t;

  typedef enum logic {
    REQ_VID = 1'b0,
    REQ_CPU = 1'b1
  } req_id_t;

  // 14-bit word address: upper 8 bits select the row, lower 6 the column.
  localparam int unsigned ROW_MSB = 13;
  localparam int unsigned ROW_LSB = 6;
  localparam int unsigned COL_MSB = 5;
  localparam int unsigned COL_LSB = 0;

  function automatic logic [7:0] row_of(input logic [13:0] addr);
    return addr[ROW_MSB:ROW_LSB];
  endfunction

  // TMS4416 column address lives on A1..A6; A0 and A7 are unused.
  function automatic logic [7:0] col_of(input logic [13:0] addr);
    return {1'b0, addr[COL_MSB:COL_LSB], 1'b0};
  endfunction

endpackage

// File: rtl/vram_refresh_timer.sv
// Refresh period counter, pending/overrun flags and RAS-only refresh row pointer.
module vram_refresh_timer #(
  parameter int unsigned REFRESH_PERIOD = 128
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       ref_grant,
  input  logic       ref_done,
  output logic       ref_pend,
  output logic       ref_overrun,
  output logic [7:0] ref_row
);

  localparam int unsigned CW = (REFRESH_PERIOD > 2) ? $clog2(REFRESH_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_PERIOD - 1);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = (cnt == LAST);

  // Free-running period counter; a wrap that coincides with a grant re-arms ref_pend.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt         <= '0;
      ref_pend    <= 1'b0;
      ref_overrun <= 1'b0;
      ref_row     <= '0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) begin
        ref_pend <= 1'b1;
        if (ref_pend) ref_overrun <= 1'b1;
      end else if (ref_grant) begin
        ref_pend <= 1'b0;
      end
      if (ref_done) ref_row <= ref_row + 8'd1;
    end
  end

endmodule

// File: rtl/vram_sequencer.sv
// Arbitrates the TMS4416 bitmap bank between CPU, video fetch and refresh,
// and drives registered RAS/CAS/G/W strobes with the multiplexed address.
module vram_sequencer
  import vram_seq_pkg::*;
#(
  parameter int unsigned REFRESH_PERIOD = 128,
  parameter int unsigned CPU_STARVE_MAX = 2
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [13:0] cpu_addr,
  input  logic [3:0]  cpu_din,
  output logic        cpu_ack,
  output logic [3:0]  cpu_rdata,
  input  logic        vid_req,
  input  logic [13:0] vid_addr,
  output logic        vid_ack,
  output logic [3:0]  vid_rdata,
  output logic        dram_rasn,
  output logic        dram_casn,
  output logic        dram_gn,
  output logic        dram_wn,
  output logic [7:0]  dram_a,
  output logic [3:0]  dram_din,
  input  logic [3:0]  dram_dout,
  output logic        busy,
  output logic        ref_overrun
);

  localparam int unsigned SW = $clog2(CPU_STARVE_MAX + 2);
  localparam logic [SW-1:0] STARVE_LIM = SW'(CPU_STARVE_MAX);

  state_t        state, state_n;
  logic [13:0]   addr_q, addr_n;
  logic          we_q, we_n;
  logic [3:0]    din_q, din_n;
  req_id_t       id_q, id_n;
  logic [SW-1:0] starve_q, starve_n;

  logic          ref_pend, ref_grant, ref_done;
  logic [7:0]    ref_row;

  logic          row_active, col_active;
  logic [7:0]    a_n;

  vram_refresh_timer #(
    .REFRESH_PERIOD(REFRESH_PERIOD)
  ) u_refresh (
    .clk        (clk),
    .clr_n      (clr_n),
    .ref_grant  (ref_grant),
    .ref_done   (ref_done),
    .ref_pend   (ref_pend),
    .ref_overrun(ref_overrun),
    .ref_row    (ref_row)
  );

  assign busy = (state != S_IDLE);

  // Next-state, arbitration and grant-time latching of the request fields.
  always_comb begin
    state_n   = state;
    addr_n    = addr_q;
    we_n      = we_q;
    din_n     = din_q;
    id_n      = id_q;
    starve_n  = starve_q;
    ref_grant = 1'b0;
    ref_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (ref_pend) begin
          state_n   = S_REF_ROW;
          ref_grant = 1'b1;
        end else if (vid_req && !(cpu_req && (starve_q >= STARVE_LIM))) begin
          state_n  = S_ROW;
          id_n     = REQ_VID;
          addr_n   = vid_addr;
          we_n     = 1'b0;
          // Only video grants made over a waiting CPU count toward starvation.
          starve_n = cpu_req ? starve_q + 1'b1 : '0;
        end else if (cpu_req) begin
          state_n  = S_ROW;
          id_n     = REQ_CPU;
          addr_n   = cpu_addr;
          we_n     = cpu_we;
          din_n    = cpu_din;
          starve_n = '0;
        end
      end
      S_ROW:      state_n = S_COL;
      S_COL:      state_n = S_DATA;
      S_DATA:     state_n = S_PRE;
      S_PRE:      state_n = S_IDLE;
      S_REF_ROW:  state_n = S_REF_HOLD;
      S_REF_HOLD: begin
        state_n  = S_PRE;
        ref_done = 1'b1;
      end
      default:    state_n = S_IDLE;
    endcase
  end

  // State and latched request registers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      din_q    <= '0;
      id_q     <= REQ_VID;
      starve_q <= '0;
    end else begin
      state    <= state_n;
      addr_q   <= addr_n;
      we_q     <= we_n;
      din_q    <= din_n;
      id_q     <= id_n;
      starve_q <= starve_n;
    end
  end

  // Strobe and address decode from the upcoming state, so outputs are glitch-free registers.
  always_comb begin
    row_active = (state_n inside {S_ROW, S_COL, S_DATA, S_REF_ROW, S_REF_HOLD});
    col_active = (state_n inside {S_COL, S_DATA});
    case (state_n)
      S_ROW:                 a_n = row_of(addr_n);
      S_COL, S_DATA:         a_n = col_of(addr_n);
      S_REF_ROW, S_REF_HOLD: a_n = ref_row;
      default:               a_n = '0;
    endcase
  end

  // Registered DRAM-side outputs.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      dram_rasn <= 1'b1;
      dram_casn <= 1'b1;
      dram_gn   <= 1'b1;
      dram_wn   <= 1'b1;
      dram_a    <= '0;
      dram_din  <= '0;
    end else begin
      dram_rasn <= !row_active;
      dram_casn <= !col_active;
      dram_gn   <= !(col_active && !we_n);
      dram_wn   <= !(col_active && we_n);
      dram_a    <= a_n;
      dram_din  <= din_n;
    end
  end

  // Completion: ack the granted port for the PRE cycle and capture read data.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cpu_ack   <= 1'b0;
      vid_ack   <= 1'b0;
      cpu_rdata <= '0;
      vid_rdata <= '0;
    end else begin
      cpu_ack <= (state == S_DATA) && (id_q == REQ_CPU);
      vid_ack <= (state == S_DATA) && (id_q == REQ_VID);
      if ((state == S_DATA) && !we_q) begin
        if (id_q == REQ_CPU) cpu_rdata <= dram_dout;
        else                 vid_rdata <= dram_dout;
      end
    end
  end

endmodule

// File: tb/tb_vram_sequencer.sv
// Directed bench for vram_sequencer with a behavioural TMS4416 bank model.
module tb_vram_sequencer;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, vid_req = 1'b0;
  logic [13:0] cpu_addr = '0, vid_addr = '0;
  logic [3:0]  cpu_din = '0;
  logic        cpu_ack, vid_ack, dram_rasn, dram_casn, dram_gn, dram_wn, busy, ref_overrun;
  logic [3:0]  cpu_rdata, vid_rdata, dram_din;
  logic [3:0]  dram_dout = '0;
  logic [7:0]  dram_a;

  // Second instance with a very short refresh period for overrun checks.
  logic        o_vid_req = 1'b0, o_zero = 1'b0;
  logic [13:0] o_addr0 = '0;
  logic [3:0]  o_nib0 = '0;
  logic        o_cpu_ack, o_vid_ack, o_rasn, o_casn, o_gn, o_wn, o_busy, o_overrun;
  logic [3:0]  o_cpu_rdata, o_vid_rdata, o_din;
  logic [7:0]  o_a;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vram_sequencer #(.REFRESH_PERIOD(128), .CPU_STARVE_MAX(2)) u_dut (
    .clk(clk), .clr_n(clr_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
    .dram_rasn(dram_rasn), .dram_casn(dram_casn), .dram_gn(dram_gn), .dram_wn(dram_wn),
    .dram_a(dram_a), .dram_din(dram_din), .dram_dout(dram_dout),
    .busy(busy), .ref_overrun(ref_overrun)
  );

  vram_sequencer #(.REFRESH_PERIOD(3), .CPU_STARVE_MAX(2)) u_ovr (
    .clk(clk), .clr_n(clr_n),
    .cpu_req(o_zero), .cpu_we(o_zero), .cpu_addr(o_addr0), .cpu_din(o_nib0),
    .cpu_ack(o_cpu_ack), .cpu_rdata(o_cpu_rdata),
    .vid_req(o_vid_req), .vid_addr(o_addr0), .vid_ack(o_vid_ack), .vid_rdata(o_vid_rdata),
    .dram_rasn(o_rasn), .dram_casn(o_casn), .dram_gn(o_gn), .dram_wn(o_wn),
    .dram_a(o_a), .dram_din(o_din), .dram_dout(o_nib0),
    .busy(o_busy), .ref_overrun(o_overrun)
  );

  // DRAM model: row latched on RAS fall, column access on any edge seeing CAS low.
  logic [3:0] mem [0:16383];
  logic [7:0] row_lat = '0;
  logic       prev_rasn = 1'b1;
  always @(posedge clk) begin
    prev_rasn <= dram_rasn;
    if (prev_rasn && !dram_rasn) row_lat <= dram_a;
    if (!dram_rasn && !dram_casn) begin
      if (!dram_wn) mem[{row_lat, dram_a[6:1]}] <= dram_din;
      if (!dram_gn) dram_dout <= mem[{row_lat, dram_a[6:1]}];
    end
  end

  task automatic test_reset();
    clr_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if ({dram_rasn, dram_casn, dram_gn, dram_wn} !== 4'b1111) begin fails++;
      $display("FAIL reset_strobes: got %b want 1111", {dram_rasn, dram_casn, dram_gn, dram_wn}); end
    tests++; if (dram_a !== 8'h00) begin fails++; $display("FAIL reset_addr: got %h want 00", dram_a); end
    tests++; if ({cpu_ack, vid_ack, busy, ref_overrun} !== 4'b0000) begin fails++;
      $display("FAIL reset_flags: ack/ack/busy/ovr got %b want 0000", {cpu_ack, vid_ack, busy, ref_overrun}); end
    tests++; if ({cpu_rdata, vid_rdata, dram_din} !== 12'h000) begin fails++;
      $display("FAIL reset_data: got %h want 000", {cpu_rdata, vid_rdata, dram_din}); end
    clr_n = 1'b1;
  endtask

  task automatic test_cpu_write_read();
    @(negedge clk);
    cpu_addr = 14'h2A5; cpu_we = 1'b1; cpu_din = 4'hC; cpu_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) begin
        tests++; if ({dram_rasn, dram_casn, dram_gn, dram_wn, busy} !== 5'b01111) begin fails++;
          $display("FAIL wr_row_strobes: got %b want 01111", {dram_rasn, dram_casn, dram_gn, dram_wn, busy}); end
        tests++; if (dram_a !== 8'h0A) begin fails++; $display("FAIL wr_row_addr: got %h want 0a", dram_a); end
      end else if (c == 2 || c == 3) begin
        tests++; if ({dram_rasn, dram_casn, dram_gn, dram_wn, cpu_ack} !== 5'b00100) begin fails++;
          $display("FAIL wr_col_strobes c%0d: got %b want 00100", c, {dram_rasn, dram_casn, dram_gn, dram_wn, cpu_ack}); end
        tests++; if ({dram_a, dram_din} !== 12'h4AC) begin fails++;
          $display("FAIL wr_col_addr_data c%0d: got %h want 4ac", c, {dram_a, dram_din}); end
      end else if (c == 4) begin
        tests++; if ({cpu_ack, dram_rasn, dram_casn, vid_ack} !== 4'b1110) begin fails++;
          $display("FAIL wr_ack: ack/ras/cas/vack got %b want 1110", {cpu_ack, dram_rasn, dram_casn, vid_ack}); end
        cpu_req = 1'b0;
      end else begin
        tests++; if ({cpu_ack, busy} !== 2'b00) begin fails++;
          $display("FAIL wr_done: ack/busy got %b want 00", {cpu_ack, busy}); end
      end
    end
    cpu_we = 1'b0; cpu_din = 4'h0; cpu_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 2 || c == 3) begin
        tests++; if ({dram_rasn, dram_casn, dram_gn, dram_wn} !== 4'b0001) begin fails++;
          $display("FAIL rd_col_strobes c%0d: got %b want 0001", c, {dram_rasn, dram_casn, dram_gn, dram_wn}); end
      end else if (c == 4) begin
        tests++; if ({cpu_ack, cpu_rdata} !== 5'b1_1100) begin fails++;
          $display("FAIL rd_ack_data: got ack=%b data=%h want ack=1 data=c", cpu_ack, cpu_rdata); end
        cpu_req = 1'b0;
      end else if (c == 5) begin
        tests++; if ({cpu_ack, cpu_rdata} !== 5'b0_1100) begin fails++;
          $display("FAIL rd_hold: got ack=%b data=%h want ack=0 data=c", cpu_ack, cpu_rdata); end
      end
    end
  endtask

  task automatic test_arbitration();
    logic [0:5] exp_seq;
    int n;
    exp_seq = 6'b001001;
    n = 0;
    @(negedge clk);
    cpu_addr = 14'h2A5; cpu_we = 1'b0; vid_addr = 14'h2A5;
    cpu_req = 1'b1; vid_req = 1'b1;
    for (int c = 0; c < 100 && n < 6; c++) begin
      @(negedge clk);
      if (cpu_ack || vid_ack) begin
        tests++; if ((cpu_ack && vid_ack) || (cpu_ack !== exp_seq[n])) begin fails++;
          $display("FAIL arb_order #%0d: got cpu=%b vid=%b want cpu=%b", n, cpu_ack, vid_ack, exp_seq[n]); end
        tests++; if ((cpu_ack ? cpu_rdata : vid_rdata) !== 4'hC) begin fails++;
          $display("FAIL arb_rdata #%0d: got %h want c", n, cpu_ack ? cpu_rdata : vid_rdata); end
        n++;
      end
    end
    cpu_req = 1'b0; vid_req = 1'b0;
    tests++; if (n != 6) begin fails++; $display("FAIL arb_timeout: got %0d acks want 6", n); end
    repeat (2) @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL arb_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_refresh();
    int start[2];
    int len[2];
    logic [7:0] ra[2];
    int nref, run;
    logic col_seen;
    start = '{0, 0}; len = '{0, 0}; ra = '{8'hFF, 8'hFF};
    nref = 0; run = 0; col_seen = 1'b0;
    @(negedge clk); clr_n = 1'b0;
    @(negedge clk); clr_n = 1'b1;
    for (int s = 1; s <= 266; s++) begin
      @(negedge clk);
      if (!dram_casn || !dram_gn || !dram_wn) col_seen = 1'b1;
      if (!dram_rasn) begin
        if (run == 0) begin
          if (nref < 2) begin start[nref] = s; ra[nref] = dram_a; end
          nref++;
        end
        run++;
      end else if (run != 0) begin
        if (nref <= 2) len[nref-1] = run;
        run = 0;
      end
    end
    tests++; if (nref != 2) begin fails++; $display("FAIL ref_count: got %0d want 2", nref); end
    tests++; if (start[0] != 129 || start[1] != 257) begin fails++;
      $display("FAIL ref_timing: got %0d,%0d want 129,257", start[0], start[1]); end
    tests++; if (ra[0] !== 8'h00 || ra[1] !== 8'h01) begin fails++;
      $display("FAIL ref_rows: got %h,%h want 00,01", ra[0], ra[1]); end
    tests++; if (len[0] != 2 || len[1] != 2) begin fails++;
      $display("FAIL ref_ras_len: got %0d,%0d want 2,2", len[0], len[1]); end
    tests++; if (col_seen !== 1'b0) begin fails++; $display("FAIL ref_col_strobes: got low=%b want 0", col_seen); end
    tests++; if (ref_overrun !== 1'b0) begin fails++; $display("FAIL ref_no_overrun: got %b want 0", ref_overrun); end
  endtask

  task automatic test_reset_mid_access();
    logic ack_seen, found;
    logic [7:0] fa;
    int fs;
    ack_seen = 1'b0; found = 1'b0; fa = 8'hFF; fs = 0;
    @(negedge clk);
    cpu_addr = 14'h2A5; cpu_we = 1'b0; cpu_req = 1'b1;
    repeat (2) @(negedge clk);
    tests++; if ({dram_rasn, dram_casn} !== 2'b00) begin fails++;
      $display("FAIL mid_in_col: ras/cas got %b want 00", {dram_rasn, dram_casn}); end
    #2 clr_n = 1'b0;
    #1;
    tests++; if ({dram_rasn, dram_casn, dram_gn, dram_wn, busy, cpu_ack} !== 6'b111100) begin fails++;
      $display("FAIL mid_async: got %b want 111100", {dram_rasn, dram_casn, dram_gn, dram_wn, busy, cpu_ack}); end
    tests++; if (cpu_rdata !== 4'h0) begin fails++; $display("FAIL mid_rdata: got %h want 0", cpu_rdata); end
    cpu_req = 1'b0;
    @(negedge clk); clr_n = 1'b1;
    for (int s = 1; s <= 200 && !found; s++) begin
      @(negedge clk);
      if (cpu_ack) ack_seen = 1'b1;
      if (!dram_rasn) begin found = 1'b1; fa = dram_a; fs = s; end
    end
    tests++; if (ack_seen !== 1'b0) begin fails++; $display("FAIL mid_no_ack: got %b want 0", ack_seen); end
    tests++; if (!found || fs != 129) begin fails++;
      $display("FAIL mid_ref_timing: found=%b at %0d want 1 at 129", found, fs); end
    tests++; if (fa !== 8'h00) begin fails++; $display("FAIL mid_ref_row: got %h want 00", fa); end
  endtask

  task automatic test_overrun();
    @(negedge clk); clr_n = 1'b0;
    @(negedge clk); clr_n = 1'b1;
    @(negedge clk);
    tests++; if (o_overrun !== 1'b0) begin fails++; $display("FAIL ovr_clear: got %b want 0", o_overrun); end
    o_vid_req = 1'b1;
    repeat (40) @(negedge clk);
    tests++; if (o_overrun !== 1'b1) begin fails++; $display("FAIL ovr_set: got %b want 1", o_overrun); end
    o_vid_req = 1'b0;
    repeat (20) @(negedge clk);
    tests++; if (o_overrun !== 1'b1) begin fails++; $display("FAIL ovr_sticky: got %b want 1", o_overrun); end
    tests++; if (ref_overrun !== 1'b0) begin fails++; $display("FAIL ovr_main_clear: got %b want 0", ref_overrun); end
  endtask

  initial begin
    test_reset();
    test_cpu_write_read();
    test_arbitration();
    test_refresh();
    test_reset_mid_access();
    test_overrun();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
